// File: rtl/dcm_prog_pkg.sv
// Shared definitions for the DCM PROG responder: FSM states, command bit
// values and field/output widths.
package dcm_prog_pkg;

  // Sequence decoder states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_END,
    ST_GO_CHK,
    ST_ABORT
  } prog_state_e;

  // Command bit values on PROGDATA
  localparam logic CMD_LOAD = 1'b1;
  localparam logic SEL_D    = 1'b0;
  localparam logic SEL_M    = 1'b1;
  localparam logic GO_BIT   = 1'b0;

  // Width of a programmed field (value-1) and of the presented value
  localparam int FIELD_W = 8;
  localparam int OUT_W   = 9;

  // Presented value is the field plus one, widened so 0xFF gives 256
  function automatic logic [OUT_W-1:0] field_to_out(input logic [FIELD_W-1:0] field);
    return {1'b0, field} + OUT_W'(1);
  endfunction

endpackage

// File: rtl/dcm_relock_timer.sv
// Relock timer: loadable down-counter that models DCM lock time and
// produces the registered prog_done flag.
module dcm_relock_timer #(
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic idle,
  output logic done
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  // Reload on apply, otherwise count down to zero; done only while idle
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOCK_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
    done_d = idle && (count_d == '0);
  end

  // Counter and done registers; reset starts a full relock period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= LOCK_VAL;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/dcm_prog_responder.sv
// Responder end of the DCM PROG serial interface. Decodes LoadD/LoadM/GO
// sequences into staged divider/multiplier fields, applies them on GO and
// holds prog_done low until the modelled relock time has elapsed.
module dcm_prog_responder
  import dcm_prog_pkg::*;
#(
  parameter int unsigned INITIAL_M   = 60,
  parameter int unsigned INITIAL_D   = 8,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             prog_en,
  input  logic             prog_data,
  output logic             prog_done,
  output logic [OUT_W-1:0] mult_out,
  output logic [OUT_W-1:0] div_out,
  output logic             cfg_update,
  output logic             prog_error
);

  localparam logic [OUT_W-1:0]   INIT_MULT    = OUT_W'(INITIAL_M);
  localparam logic [OUT_W-1:0]   INIT_DIV     = OUT_W'(INITIAL_D);
  localparam logic [FIELD_W-1:0] INIT_M_FIELD = FIELD_W'(INITIAL_M - 1);
  localparam logic [FIELD_W-1:0] INIT_D_FIELD = FIELD_W'(INITIAL_D - 1);

  prog_state_e        state_q, state_d;
  logic               target_q, target_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [FIELD_W-1:0] shift_q, shift_d;
  logic [FIELD_W-1:0] staged_m_q, staged_m_d;
  logic [FIELD_W-1:0] staged_d_q, staged_d_d;
  logic [OUT_W-1:0]   mult_q, mult_d;
  logic [OUT_W-1:0]   div_q, div_d;
  logic               cfg_update_q, cfg_update_d;
  logic               prog_error_q, prog_error_d;
  logic               apply;

  // Sequence decoder: next state, shifting, staging and apply
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    staged_m_d   = staged_m_q;
    staged_d_d   = staged_d_q;
    mult_d       = mult_q;
    div_d        = div_q;
    cfg_update_d = 1'b0;
    prog_error_d = 1'b0;
    apply        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (prog_en) begin
          if (prog_data == CMD_LOAD) begin
            state_d = ST_CMD;
          end else begin
            state_d = ST_GO_CHK;
          end
        end
      end

      ST_CMD: begin
        if (!prog_en) begin
          prog_error_d = 1'b1;
          shift_d      = '0;
          state_d      = ST_IDLE;
        end else begin
          target_d = prog_data;
          cnt_d    = 3'd0;
          state_d  = ST_DATA;
        end
      end

      ST_DATA: begin
        if (!prog_en) begin
          prog_error_d = 1'b1;
          shift_d      = '0;
          cnt_d        = 3'd0;
          state_d      = ST_IDLE;
        end else begin
          shift_d[cnt_q] = prog_data;
          cnt_d          = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ST_END;
          end
        end
      end

      ST_END: begin
        if (!prog_en) begin
          if (target_q == SEL_M) begin
            staged_m_d = shift_q;
          end else begin
            staged_d_d = shift_q;
          end
          state_d = ST_IDLE;
        end else begin
          prog_error_d = 1'b1;
          shift_d      = '0;
          state_d      = ST_ABORT;
        end
      end

      ST_GO_CHK: begin
        if (!prog_en) begin
          mult_d       = field_to_out(staged_m_q);
          div_d        = field_to_out(staged_d_q);
          cfg_update_d = 1'b1;
          apply        = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          prog_error_d = 1'b1;
          state_d      = ST_ABORT;
        end
      end

      ST_ABORT: begin
        if (!prog_en) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decoder, staging and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      target_q     <= SEL_D;
      cnt_q        <= 3'd0;
      shift_q      <= '0;
      staged_m_q   <= INIT_M_FIELD;
      staged_d_q   <= INIT_D_FIELD;
      mult_q       <= INIT_MULT;
      div_q        <= INIT_DIV;
      cfg_update_q <= 1'b0;
      prog_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      staged_m_q   <= staged_m_d;
      staged_d_q   <= staged_d_d;
      mult_q       <= mult_d;
      div_q        <= div_d;
      cfg_update_q <= cfg_update_d;
      prog_error_q <= prog_error_d;
    end
  end

  // prog_done follows the relock timer, gated to the idle state
  dcm_relock_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_relock_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (apply),
    .idle   (state_d == ST_IDLE),
    .done   (prog_done)
  );

  assign mult_out   = mult_q;
  assign div_out    = div_q;
  assign cfg_update = cfg_update_q;
  assign prog_error = prog_error_q;

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Self-checking bench for dcm_prog_responder: directed protocol scenarios
// followed by randomized command streams, with a scoreboard of expected
// cfg_update / prog_error events and the values presented with them.
module tb_dcm_prog_responder;

  localparam int LOCK = 64;

  logic       clk;
  logic       reset_n;
  logic       prog_en;
  logic       prog_data;
  logic       prog_done;
  logic [8:0] mult_out;
  logic [8:0] div_out;
  logic       cfg_update;
  logic       prog_error;

  typedef struct {
    logic [1:0] kind;
    logic [8:0] mult;
    logic [8:0] div;
  } event_t;

  localparam logic [1:0] EV_CFG = 2'b10;
  localparam logic [1:0] EV_ERR = 2'b01;

  event_t expQ[$];
  int tests = 0;
  int fails = 0;

  // Reference model: staged fields and presented values
  int stagedM, stagedD, activeM, activeD;

  dcm_prog_responder #(
    .INITIAL_M  (60),
    .INITIAL_D  (8),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .prog_en   (prog_en),
    .prog_data (prog_data),
    .prog_done (prog_done),
    .mult_out  (mult_out),
    .div_out   (div_out),
    .cfg_update(cfg_update),
    .prog_error(prog_error)
  );

  // Free-running programming clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic data);
    prog_en   = en;
    prog_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    stagedM = 59;
    stagedD = 7;
    activeM = 60;
    activeD = 8;
  endtask

  task automatic pushErr();
    expQ.push_back('{EV_ERR, 9'(activeM), 9'(activeD)});
  endtask

  task automatic sendGap(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic sendLoad(input logic sel, input logic [7:0] field);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, sel);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, field[i]);
    applyStimulus(1'b0, 1'b0);
    if (sel) stagedM = field;
    else     stagedD = field;
  endtask

  task automatic sendGo();
    activeM = stagedM + 1;
    activeD = stagedD + 1;
    expQ.push_back('{EV_CFG, 9'(activeM), 9'(activeD)});
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  // Load aborted after nBits data bits (-1 means en drops in the select slot)
  task automatic sendBadLoad(input logic sel, input int nBits);
    pushErr();
    applyStimulus(1'b1, 1'b1);
    if (nBits >= 0) begin
      applyStimulus(1'b1, sel);
      for (int i = 0; i < nBits; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  // GO with en held for 1 + hold cycles
  task automatic sendGoHeld(input int hold);
    pushErr();
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < hold; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    applyStimulus(1'b0, 1'b0);
  endtask

  // Full load but en stays high past the last data bit
  task automatic sendLongLoad(input logic sel, input logic [7:0] field, input int extra);
    pushErr();
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, sel);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, field[i]);
    for (int i = 0; i < extra; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    applyStimulus(1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected event
  task automatic runMonitor();
    event_t ev;
    forever begin
      @(negedge clk);
      if (reset_n && (cfg_update || prog_error)) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected event: got cfg_update=%0b prog_error=%0b, required none",
                   cfg_update, prog_error);
        end else begin
          ev = expQ.pop_front();
          checkOutput("event kind", int'({cfg_update, prog_error}), int'(ev.kind));
          checkOutput("event mult_out", int'(mult_out), int'(ev.mult));
          checkOutput("event div_out", int'(div_out), int'(ev.div));
        end
      end
    end
  endtask

  initial begin
    int n;
    int op;
    fork
      runMonitor();
    join_none

    // Reset values and initial relock period
    prog_en   = 1'b0;
    prog_data = 1'b0;
    reset_n   = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset prog_done", int'(prog_done), 0);
    checkOutput("reset mult_out", int'(mult_out), 60);
    checkOutput("reset div_out", int'(div_out), 8);
    checkOutput("reset cfg_update", int'(cfg_update), 0);
    checkOutput("reset prog_error", int'(prog_error), 0);
    reset_n = 1'b1;
    n = 0;
    while (!prog_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("initial relock cycles", n, LOCK);

    // LoadD 7, LoadM 59, GO with 3-cycle gaps; check pulse latency and relock
    sendLoad(1'b0, 8'd7);
    sendGap(2);
    sendLoad(1'b1, 8'd59);
    sendGap(2);
    activeM = stagedM + 1;
    activeD = stagedD + 1;
    expQ.push_back('{EV_CFG, 9'(activeM), 9'(activeD)});
    applyStimulus(1'b1, 1'b0);
    checkOutput("prog_done low in GO_CHK", int'(prog_done), 0);
    n = 0;
    while (!prog_done && n < 200) begin
      applyStimulus(1'b0, 1'b0);
      n++;
      if (n == 1) checkOutput("cfg_update after GO", int'(cfg_update), 1);
      if (n == 2) checkOutput("cfg_update single pulse", int'(cfg_update), 0);
    end
    checkOutput("GO relock cycles", n, LOCK + 1);
    checkOutput("applied mult_out", int'(mult_out), 60);
    checkOutput("applied div_out", int'(div_out), 8);

    // LoadM 87 then GO, then a repeat GO with no load
    sendLoad(1'b1, 8'd87);
    sendGo();
    sendGap(2);
    sendGo();
    sendGap(1);

    // en drops after data bit 4 of a LoadM; GO keeps the old multiplier
    sendBadLoad(1'b1, 5);
    sendGo();
    checkOutput("mult after aborted load", int'(mult_out), 88);

    // GO held two cycles, then held in ABORT longer before a valid load/GO
    sendGoHeld(1);
    sendGap(1);
    sendGoHeld(3);
    sendLoad(1'b0, 8'd3);
    sendGo();

    // Async reset mid-DATA of LoadM 0xFF, then a clean LoadM 0xFF and GO
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    prog_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset mult_out", int'(mult_out), 60);
    checkOutput("async reset div_out", int'(div_out), 8);
    checkOutput("async reset prog_done", int'(prog_done), 0);
    modelReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sendGap(1);
    sendLoad(1'b1, 8'hFF);
    sendGo();
    checkOutput("field 0xFF mult_out", int'(mult_out), 256);
    sendGap(1);

    // Randomized command stream against the reference model
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 8);
      case (op)
        0, 1:    sendLoad(1'b0, 8'($urandom_range(0, 255)));
        2, 3:    sendLoad(1'b1, 8'($urandom_range(0, 255)));
        4, 5:    sendGo();
        6:       sendBadLoad(1'($urandom_range(0, 1)), $urandom_range(0, 8) - 1);
        7:       sendGoHeld($urandom_range(1, 3));
        default: sendLongLoad(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                              $urandom_range(1, 3));
      endcase
      sendGap($urandom_range(0, 2));
    end

    sendGap(5);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcm_prog_responder.md
Name: dcm_prog_responder

Overview:
- Responder end of the DCM PROG serial interface (PROGEN/PROGDATA sampled on the programming clock, PROGDONE returned).
- Decodes LoadD, LoadM and GO sequences into staged divider/multiplier values and applies them on GO.
- Models relock time before re-asserting prog_done.
- Used as the clock-generator model in the miner benches and as the soft frequency-word source for non-DCM clocking.

Parameters:
- INITIAL_M, 60, multiplier value presented after reset (range 2..256).
- INITIAL_D, 8, divider value presented after reset (range 1..256).
- LOCK_CYCLES, 64, cycles from GO (or reset) until prog_done rises (≥1).

Ports:
- clk  in  1  programming clock; all sampling on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- prog_en  in  1  PROGEN from the controller.
- prog_data  in  1  PROGDATA from the controller.
- prog_done  out  1  high when locked and idle.
- mult_out  out  9  active multiplier (M field + 1).
- div_out  out  9  active divider (D field + 1).
- cfg_update  out  1  one-cycle pulse when new values are applied.
- prog_error  out  1  one-cycle pulse on a malformed sequence.

Behaviour:
- Reset values:
  - prog_done=0, cfg_update=0, prog_error=0.
  - mult_out=INITIAL_M, div_out=INITIAL_D.
  - Staged D/M = active values.
  - Relock timer loaded with LOCK_CYCLES; prog_done rises when it expires.
  - FSM in IDLE.
- Protocol, per sampled cycle:
  - Load command: en=1 for 10 cycles. Bit0=1, then bit1 (0 selects D, 1 selects M), then 8 data bits LSB first holding value−1, then en=0.
  - GO: en=1 with data=0 for exactly one cycle, followed by en=0.
- FSM states: IDLE, CMD, DATA, END, GO_CHK, ABORT.
  - IDLE, en=0: stay.
  - IDLE, en=1, data=1: go to CMD; prog_done←0 on the next edge.
  - IDLE, en=1, data=0: go to GO_CHK.
  - CMD: if en=0, error. Otherwise latch target = data (0 selects D, 1 selects M), clear bit counter, go to DATA.
  - DATA: if en=0, error. Otherwise shift[cnt]←data; after the 8th bit (cnt=7) go to END.
  - END: if en=0, write shift into the staged register for the target and go to IDLE. If en=1, error.
  - GO_CHK, en=0 (apply):
    - mult_out←staged M+1, div_out←staged D+1.
    - cfg_update pulses on the next cycle.
    - prog_done←0; timer reloaded with LOCK_CYCLES.
    - Go to IDLE.
  - GO_CHK, en=1: error.
  - ABORT: wait for en=0, then go to IDLE; no other actions.
- Error handling: prog_error pulses for one cycle. The partial shift is discarded and staged values are unchanged. Go to ABORT, or straight to IDLE if en is already 0.
- Relock timer:
  - Decrements each cycle while nonzero; prog_done←1 on the cycle it reaches 0.
  - A load command while the timer runs is accepted and keeps prog_done low.
  - Timer expiry alone does not raise prog_done while the FSM is outside IDLE. prog_done rises on the first IDLE cycle with the timer at 0.
- GO with no preceding load re-applies current staged values: cfg_update pulses and relock still occurs.
- Staged field 0xFF gives 256 (9-bit output, no wrap).
- Field 0 for M gives mult_out=1. This is passed through unmodified; range checks belong to the controller.
- Back-to-back commands need at least one en=0 cycle between them; END/GO_CHK enforce this.
- Asynchronous reset mid-sequence: outputs return to reset values immediately and the partial command is lost.

Decomposition:
- dcm_prog_pkg holds:
  - FSM state enum.
  - Command bit constants: CMD_LOAD=1, SEL_D=0, SEL_M=1, GO_BIT=0.
  - Field width (8) and output width (9).
- One sub-module, dcm_relock_timer: loadable down-counter with parameter LOCK_CYCLES, inputs load and idle, output done.

Test Plan:
- Reset release with LOCK_CYCLES=64: mult_out=60, div_out=8; prog_done rises exactly 64 cycles after reset_n deasserts.
- LoadD field 7, LoadM field 59, then GO, with 3-cycle en-low gaps: cfg_update pulses once 2 cycles after the GO cycle; mult_out=60, div_out=8; prog_done low for 64 cycles, then high.
- LoadM field 87, then GO: mult_out=88, div_out unchanged; a second GO with no load pulses cfg_update again with the same values.
- en drops after data bit 4 of a LoadM: prog_error pulses; a following GO leaves mult_out at its previous value.
- GO with en held 2 cycles: prog_error pulses, no cfg_update; the FSM waits in ABORT until en=0.
- Assert reset_n low mid-DATA of a LoadM field 0xFF, then release: outputs return to 60/8; a subsequent full LoadM field 0xFF and GO gives mult_out=256.
